// File: rtl/regfile_wr_arbiter.sv
// Register-file write-port arbiter: two writeback requesters plus a register-move requester,
// with a pending-write scoreboard for decode hazard detection. Regfile-side outputs are registered.
module regfile_wr_arbiter #(
  parameter int unsigned BIT       = 8,
  parameter int unsigned SZB       = 4,
  parameter int unsigned MV_STARVE = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wb0_valid,
  input  logic [SZB-1:0]    wb0_addr,
  input  logic [BIT-1:0]    wb0_data,
  output logic              wb0_ready,
  input  logic              wb1_valid,
  input  logic [SZB-1:0]    wb1_addr,
  input  logic [BIT-1:0]    wb1_data,
  output logic              wb1_ready,
  input  logic              mv_valid,
  input  logic [SZB-1:0]    mv_src,
  input  logic [SZB-1:0]    mv_dst,
  output logic              mv_ready,
  input  logic              issue_valid,
  input  logic [SZB-1:0]    issue_rd,
  input  logic [SZB-1:0]    chk_rs0,
  input  logic [SZB-1:0]    chk_rs1,
  input  logic [SZB-1:0]    chk_rd,
  output logic              hazard,
  output logic [2**SZB-1:0] pending,
  output logic              rf_we,
  output logic              rf_mv,
  output logic [SZB-1:0]    rf_addr_rd,
  output logic [SZB-1:0]    rf_addr_rs,
  output logic [BIT-1:0]    rf_data
);

  localparam int unsigned NReg = 2**SZB;
  localparam logic [3:0] StarveMax = 4'(MV_STARVE);

  typedef enum logic [1:0] {GntNone, GntWb0, GntWb1, GntMv} gnt_e;

  gnt_e gnt;

  logic            rf_we_q, rf_we_d;
  logic            rf_mv_q, rf_mv_d;
  logic [SZB-1:0]  rf_addr_rd_q, rf_addr_rd_d;
  logic [SZB-1:0]  rf_addr_rs_q, rf_addr_rs_d;
  logic [BIT-1:0]  rf_data_q, rf_data_d;
  logic [NReg-1:0] pending_q, pending_d;
  logic [3:0]      starve_cnt_q, starve_cnt_d;
  logic            rr_last_q, rr_last_d;
  logic [NReg-1:0] clr_mask, set_mask;

  // A move that has waited long enough pre-empts both writeback ports.
  always_comb begin
    gnt = GntNone;
    if (mv_valid && (starve_cnt_q == StarveMax)) begin
      gnt = GntMv;
    end else if (wb0_valid && wb1_valid) begin
      gnt = rr_last_q ? GntWb0 : GntWb1;
    end else if (wb0_valid) begin
      gnt = GntWb0;
    end else if (wb1_valid) begin
      gnt = GntWb1;
    end else if (mv_valid) begin
      gnt = GntMv;
    end
  end

  assign wb0_ready = (gnt == GntWb0);
  assign wb1_ready = (gnt == GntWb1);
  assign mv_ready  = (gnt == GntMv);

  always_comb begin
    rf_we_d      = 1'b0;
    rf_mv_d      = 1'b0;
    rf_addr_rd_d = rf_addr_rd_q;
    rf_addr_rs_d = rf_addr_rs_q;
    rf_data_d    = rf_data_q;
    rr_last_d    = rr_last_q;
    clr_mask     = '0;
    unique case (gnt)
      GntWb0: begin
        rf_we_d      = 1'b1;
        rf_addr_rd_d = wb0_addr;
        rf_data_d    = wb0_data;
        rr_last_d    = 1'b0;
        clr_mask     = NReg'(1) << wb0_addr;
      end
      GntWb1: begin
        rf_we_d      = 1'b1;
        rf_addr_rd_d = wb1_addr;
        rf_data_d    = wb1_data;
        rr_last_d    = 1'b1;
        clr_mask     = NReg'(1) << wb1_addr;
      end
      GntMv: begin
        rf_mv_d      = 1'b1;
        rf_addr_rd_d = mv_dst;
        rf_addr_rs_d = mv_src;
        clr_mask     = NReg'(1) << mv_dst;
      end
      default: ;
    endcase
  end

  // Set wins over clear: a newly issued producer is still outstanding.
  always_comb begin
    set_mask  = issue_valid ? (NReg'(1) << issue_rd) : '0;
    pending_d = (pending_q & ~clr_mask) | set_mask;
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!mv_valid || (gnt == GntMv)) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q < StarveMax) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rf_we_q      <= 1'b0;
      rf_mv_q      <= 1'b0;
      rf_addr_rd_q <= '0;
      rf_addr_rs_q <= '0;
      rf_data_q    <= '0;
      pending_q    <= '0;
      starve_cnt_q <= '0;
      rr_last_q    <= 1'b1;
    end else begin
      rf_we_q      <= rf_we_d;
      rf_mv_q      <= rf_mv_d;
      rf_addr_rd_q <= rf_addr_rd_d;
      rf_addr_rs_q <= rf_addr_rs_d;
      rf_data_q    <= rf_data_d;
      pending_q    <= pending_d;
      starve_cnt_q <= starve_cnt_d;
      rr_last_q    <= rr_last_d;
    end
  end

  assign hazard     = pending_q[chk_rs0] | pending_q[chk_rs1] | pending_q[chk_rd];
  assign pending    = pending_q;
  assign rf_we      = rf_we_q;
  assign rf_mv      = rf_mv_q;
  assign rf_addr_rd = rf_addr_rd_q;
  assign rf_addr_rs = rf_addr_rs_q;
  assign rf_data    = rf_data_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Bench for regfile_wr_arbiter: directed literal checks followed by randomized traffic, all
// compared every cycle against a request-level model of grants, scoreboard and output registers.
module tb_regfile_wr_arbiter;

  localparam int BIT = 8;
  localparam int SZB = 4;
  localparam int MVS = 4;
  localparam int NREG = 2**SZB;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic wb0_valid = 1'b0, wb1_valid = 1'b0, mv_valid = 1'b0, issue_valid = 1'b0;
  logic [SZB-1:0] wb0_addr = '0, wb1_addr = '0, mv_src = '0, mv_dst = '0, issue_rd = '0;
  logic [SZB-1:0] chk_rs0 = '0, chk_rs1 = '0, chk_rd = '0;
  logic [BIT-1:0] wb0_data = '0, wb1_data = '0;
  logic wb0_ready, wb1_ready, mv_ready, hazard, rf_we, rf_mv;
  logic [NREG-1:0] pending;
  logic [SZB-1:0] rf_addr_rd, rf_addr_rs;
  logic [BIT-1:0] rf_data;

  regfile_wr_arbiter #(.BIT(BIT), .SZB(SZB), .MV_STARVE(MVS)) dut (
    .clock(clock), .reset(reset),
    .wb0_valid(wb0_valid), .wb0_addr(wb0_addr), .wb0_data(wb0_data), .wb0_ready(wb0_ready),
    .wb1_valid(wb1_valid), .wb1_addr(wb1_addr), .wb1_data(wb1_data), .wb1_ready(wb1_ready),
    .mv_valid(mv_valid), .mv_src(mv_src), .mv_dst(mv_dst), .mv_ready(mv_ready),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .chk_rs0(chk_rs0), .chk_rs1(chk_rs1), .chk_rd(chk_rd), .hazard(hazard),
    .pending(pending), .rf_we(rf_we), .rf_mv(rf_mv), .rf_addr_rd(rf_addr_rd),
    .rf_addr_rs(rf_addr_rs), .rf_data(rf_data)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;

  // Model state: who won, how long the move has waited, which wb port went last.
  bit              m_init = 0;
  int              m_gnt = 0;  // 0 none, 1 wb0, 2 wb1, 3 mv
  int              m_wait = 0, n_wait = 0;
  int              m_last = 1, n_last = 1;
  bit [NREG-1:0]   m_pend = '0, n_pend = '0;
  bit              m_we = 0, n_we = 0, m_mv = 0, n_mv = 0;
  bit [SZB-1:0]    m_rd = '0, n_rd = '0, m_rs = '0, n_rs = '0;
  bit [BIT-1:0]    m_data = '0, n_data = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Let inputs settle, predict this cycle's grant and next state, check combinational outputs.
  task automatic settle();
    #1;
    if (mv_valid && m_wait >= MVS) m_gnt = 3;
    else if (wb0_valid && wb1_valid) m_gnt = (m_last == 1) ? 1 : 2;
    else if (wb0_valid) m_gnt = 1;
    else if (wb1_valid) m_gnt = 2;
    else if (mv_valid) m_gnt = 3;
    else m_gnt = 0;

    n_we = (m_gnt == 1 || m_gnt == 2);
    n_mv = (m_gnt == 3);
    n_rd = m_rd; n_rs = m_rs; n_data = m_data; n_last = m_last; n_pend = m_pend;
    if (m_gnt == 1) begin n_rd = wb0_addr; n_data = wb0_data; n_last = 0; end
    if (m_gnt == 2) begin n_rd = wb1_addr; n_data = wb1_data; n_last = 1; end
    if (m_gnt == 3) begin n_rd = mv_dst; n_rs = mv_src; end
    if (n_we || n_mv) n_pend[n_rd] = 1'b0;
    if (issue_valid) n_pend[issue_rd] = 1'b1;
    n_wait = (!mv_valid || m_gnt == 3) ? 0 : ((m_wait + 1 > MVS) ? MVS : m_wait + 1);

    if (m_init) begin
      chk("wb0_ready", wb0_ready, 32'(m_gnt == 1));
      chk("wb1_ready", wb1_ready, 32'(m_gnt == 2));
      chk("mv_ready", mv_ready, 32'(m_gnt == 3));
      chk("hazard", hazard, 32'(m_pend[chk_rs0] | m_pend[chk_rs1] | m_pend[chk_rd]));
    end
  endtask

  // Advance one clock edge, commit the model, check registered outputs.
  task automatic tick();
    @(posedge clock);
    #1;
    if (reset) begin
      m_init = 1;
      m_we = 0; m_mv = 0; m_rd = '0; m_rs = '0; m_data = '0;
      m_pend = '0; m_wait = 0; m_last = 1;
    end else begin
      m_we = n_we; m_mv = n_mv; m_rd = n_rd; m_rs = n_rs; m_data = n_data;
      m_pend = n_pend; m_wait = n_wait; m_last = n_last;
    end
    if (m_init) begin
      chk("rf_we", rf_we, 32'(m_we));
      chk("rf_mv", rf_mv, 32'(m_mv));
      chk("rf_addr_rd", rf_addr_rd, 32'(m_rd));
      chk("rf_addr_rs", rf_addr_rs, 32'(m_rs));
      chk("rf_data", rf_data, 32'(m_data));
      chk("pending", pending, 32'(m_pend));
    end
  endtask

  task automatic step();
    settle();
    tick();
  endtask

  task automatic quiet();
    wb0_valid = 0; wb1_valid = 0; mv_valid = 0; issue_valid = 0;
  endtask

  task automatic do_reset();
    reset = 1; step(); reset = 0;
  endtask

  initial begin
    quiet();
    do_reset();
    chk("rst_rf_we", rf_we, 0);
    chk("rst_rf_mv", rf_mv, 0);
    chk("rst_addr", rf_addr_rd, 0);
    chk("rst_data", rf_data, 0);
    chk("rst_pending", pending, 0);

    // Single ALU write.
    wb0_valid = 1; wb0_addr = 3; wb0_data = 8'h5A;
    settle();
    chk("lit_wb0_ready", wb0_ready, 1);
    tick();
    chk("lit_wb0_we", rf_we, 1);
    chk("lit_wb0_addr", rf_addr_rd, 3);
    chk("lit_wb0_data", rf_data, 8'h5A);
    quiet();
    step();
    chk("lit_wb0_idle", rf_we, 0);

    // Round-robin between both wb ports.
    do_reset();
    wb0_valid = 1; wb0_addr = 1; wb0_data = 8'h11;
    wb1_valid = 1; wb1_addr = 2; wb1_data = 8'h22;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("lit_rr_wb0_ready", wb0_ready, 32'(i % 2 == 0));
      tick();
      chk("lit_rr_addr", rf_addr_rd, (i % 2 == 0) ? 1 : 2);
    end

    // Move starved by continuous wb traffic, promoted after MVS deferrals.
    mv_valid = 1; mv_src = 5; mv_dst = 6;
    for (int i = 0; i <= MVS; i++) begin
      settle();
      chk("lit_mv_ready", mv_ready, 32'(i == MVS));
      tick();
    end
    chk("lit_mv_rf_mv", rf_mv, 1);
    chk("lit_mv_rf_we", rf_we, 0);
    chk("lit_mv_rs", rf_addr_rs, 5);
    chk("lit_mv_rd", rf_addr_rd, 6);
    settle();
    chk("lit_mv_restarved", mv_ready, 0);
    tick();
    quiet();
    step();

    // Scoreboard set, hazard, clear, and set-beats-clear.
    issue_valid = 1; issue_rd = 7;
    step();
    issue_valid = 0;
    chk("lit_pend7_set", pending[7], 1);
    chk_rs0 = 7;
    settle();
    chk("lit_hazard_set", hazard, 1);
    tick();
    wb1_valid = 1; wb1_addr = 7; wb1_data = 8'h77;
    settle();
    chk("lit_wb1_ready", wb1_ready, 1);
    tick();
    wb1_valid = 0;
    chk("lit_pend7_clr", pending[7], 0);
    settle();
    chk("lit_hazard_clr", hazard, 0);
    tick();
    issue_valid = 1; issue_rd = 7; wb1_valid = 1;
    step();
    quiet();
    chk("lit_pend7_setwins", pending[7], 1);

    // Reset kills an in-flight grant and restores wb0 priority.
    reset = 1; wb0_valid = 1; wb0_addr = 4; wb0_data = 8'h44;
    step();
    reset = 0;
    chk("lit_rst_gnt_we", rf_we, 0);
    chk("lit_rst_gnt_pend", pending, 0);
    wb1_valid = 1; wb1_addr = 9; wb1_data = 8'h99;
    settle();
    chk("lit_rst_wb0_first", {wb0_ready, wb1_ready}, 2'b10);
    tick();
    chk("lit_rst_wb0_addr", rf_addr_rd, 4);
    quiet();
    step();

    // Random traffic; requesters hold their request until accepted (or occasionally drop it).
    for (int c = 0; c < 3000; c++) begin
      if (!(wb0_valid && m_gnt != 1 && $urandom_range(15) != 0)) begin
        wb0_valid = ($urandom_range(1) == 1);
        wb0_addr = SZB'($urandom); wb0_data = BIT'($urandom);
      end
      if (!(wb1_valid && m_gnt != 2 && $urandom_range(15) != 0)) begin
        wb1_valid = ($urandom_range(2) != 0);
        wb1_addr = SZB'($urandom); wb1_data = BIT'($urandom);
      end
      if (!(mv_valid && m_gnt != 3 && $urandom_range(15) != 0)) begin
        mv_valid = ($urandom_range(2) == 0);
        mv_src = SZB'($urandom); mv_dst = SZB'($urandom);
      end
      issue_valid = ($urandom_range(3) == 0);
      issue_rd = SZB'($urandom);
      chk_rs0 = SZB'($urandom); chk_rs1 = SZB'($urandom); chk_rd = SZB'($urandom);
      reset = ($urandom_range(99) == 0);
      step();
    end
    reset = 0;
    quiet();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
